// File: rtl/bp_me_stream_pump_out.sv
// Outbound stream pump: FSM beats in, BedRock header/data out through one-entry registers (1-cycle latency).
// Beats stall while the target output register is full and not draining; header and data channels drain independently.
module bp_me_stream_pump_out #(
    parameter int          paddr_width_p       = 40,
    parameter int          stream_data_width_p = 64,
    parameter int          block_width_p       = 512,
    parameter int          payload_width_p     = 16,
    parameter logic [15:0] msg_stream_mask_p   = '0,
    parameter logic [15:0] fsm_stream_mask_p   = msg_stream_mask_p,
    parameter logic [15:0] msg_data_mask_p     = msg_stream_mask_p,
    localparam int xce_header_width_lp = payload_width_p + 3 + paddr_width_p + 4,
    localparam int stream_words_lp     = block_width_p / stream_data_width_p,
    localparam int cnt_width_lp        = (stream_words_lp > 1) ? $clog2(stream_words_lp) : 1
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,

    input  logic [xce_header_width_lp-1:0] fsm_base_header_i,
    input  logic [stream_data_width_p-1:0] fsm_data_i,
    input  logic                           fsm_v_i,
    output logic                           fsm_ready_and_o,
    output logic [paddr_width_p-1:0]       fsm_addr_o,
    output logic [cnt_width_lp-1:0]        fsm_cnt_o,
    output logic                           fsm_new_o,
    output logic                           fsm_last_o,
    output logic                           fsm_done_o,

    output logic [xce_header_width_lp-1:0] msg_header_o,
    output logic                           msg_header_v_o,
    input  logic                           msg_header_ready_and_i,
    output logic                           msg_has_data_o,
    output logic [stream_data_width_p-1:0] msg_data_o,
    output logic                           msg_data_v_o,
    input  logic                           msg_data_ready_and_i,
    output logic                           msg_last_o
);

    localparam int stream_bytes_lp = stream_data_width_p / 8;
    localparam int lg_bytes_lp     = $clog2(stream_bytes_lp);

    typedef struct packed {
        logic [payload_width_p-1:0] payload;
        logic [2:0]                 size;
        logic [paddr_width_p-1:0]   addr;
        logic [3:0]                 msg_type;
    } hdr_t;

    typedef enum logic [1:0] {
        e_ready  = 2'd0,
        e_burst  = 2'd1,
        e_gather = 2'd2
    } state_e;

    state_e                  state_r, state_n;
    hdr_t                    hdr_r, base_hdr;
    logic [cnt_width_lp-1:0] cnt_r, cnt_n;
    logic [cnt_width_lp-1:0] size_beats, base_idx, wrap_idx;
    logic                    nz, fsm_stream, msg_stream, has_data;
    logic                    do_burst, do_gather, single;
    logic                    beat_has_data, hdr_ok, data_ok;
    logic                    accept, hdr_load, data_load;
    logic                    unused_payload;

    // The first beat describes its message from the live header; later beats use the latched copy.
    always_comb begin
        base_hdr = (state_r == e_ready) ? hdr_t'(fsm_base_header_i) : hdr_r;
    end

    assign unused_payload = ^base_hdr.payload;

    // size_beats = max(bytes/stream_bytes, 1) - 1, i.e. (size - lg_bytes) low ones, capped at the counter width
    always_comb begin
        size_beats = '0;
        for (int i = 0; i < cnt_width_lp; i++) begin
            if (int'(base_hdr.size) > lg_bytes_lp + i) begin
                size_beats[i] = 1'b1;
            end
        end
    end

    assign nz         = |size_beats;
    assign fsm_stream = fsm_stream_mask_p[base_hdr.msg_type];
    assign msg_stream = msg_stream_mask_p[base_hdr.msg_type];
    assign has_data   = msg_data_mask_p[base_hdr.msg_type];
    assign do_burst   = fsm_stream & msg_stream & nz;
    assign do_gather  = fsm_stream & ~msg_stream & nz;
    assign single     = (state_r == e_ready) & ~do_burst & ~do_gather;

    // Wrap the beat index inside the size-aligned window; higher index bits come from the base.
    assign base_idx = base_hdr.addr[lg_bytes_lp +: cnt_width_lp];
    assign wrap_idx = (base_idx & ~size_beats) | ((base_idx + cnt_r) & size_beats);

    always_comb begin
        fsm_addr_o = base_hdr.addr;
        fsm_addr_o[lg_bytes_lp +: cnt_width_lp] = wrap_idx;
    end

    assign fsm_cnt_o  = cnt_r;
    assign fsm_new_o  = (state_r == e_ready);
    assign fsm_last_o = single | (cnt_r == size_beats);

    always_comb begin
        case (state_r)
            e_ready: beat_has_data = has_data;
            e_burst: beat_has_data = 1'b1;
            default: beat_has_data = 1'b0;
        endcase
    end

    assign hdr_ok          = ~fsm_new_o | ~msg_header_v_o | msg_header_ready_and_i;
    assign data_ok         = ~beat_has_data | ~msg_data_v_o | msg_data_ready_and_i;
    assign fsm_ready_and_o = hdr_ok & data_ok;

    assign accept    = fsm_v_i & fsm_ready_and_o;
    assign hdr_load  = accept & fsm_new_o;
    assign data_load = accept & beat_has_data;

    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        if (accept) begin
            cnt_n = fsm_last_o ? '0 : cnt_r + cnt_width_lp'(1);
        end
        case (state_r)
            e_ready: begin
                if (accept) begin
                    if (do_burst) begin
                        state_n = e_burst;
                    end else if (do_gather) begin
                        state_n = e_gather;
                    end
                end
            end
            e_burst, e_gather: begin
                if (accept && fsm_last_o) begin
                    state_n = e_ready;
                end
            end
            default: state_n = e_ready;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r    <= e_ready;
            cnt_r      <= '0;
            hdr_r      <= '0;
            fsm_done_o <= 1'b0;
        end else begin
            state_r    <= state_n;
            cnt_r      <= cnt_n;
            fsm_done_o <= accept & fsm_last_o;
            if (hdr_load) begin
                hdr_r <= hdr_t'(fsm_base_header_i);
            end
        end
    end

    // Header register: may reload in the same cycle it drains.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            msg_header_o   <= '0;
            msg_header_v_o <= 1'b0;
            msg_has_data_o <= 1'b0;
        end else if (hdr_load) begin
            msg_header_o   <= fsm_base_header_i;
            msg_header_v_o <= 1'b1;
            msg_has_data_o <= has_data;
        end else if (msg_header_ready_and_i) begin
            msg_header_v_o <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            msg_data_o   <= '0;
            msg_data_v_o <= 1'b0;
            msg_last_o   <= 1'b0;
        end else if (data_load) begin
            msg_data_o   <= fsm_data_i;
            msg_data_v_o <= 1'b1;
            msg_last_o   <= fsm_last_o;
        end else if (msg_data_ready_and_i) begin
            msg_data_v_o <= 1'b0;
        end
    end

endmodule
